udp_builder: RTL and testbench

- Transmit-side counterpart of udp_parser: builds UDP datagrams for the IP transmit layer.
- Accepts application payload bytes one per cycle and buffers the whole payload, because the UDP length field precedes the data.
- Then emits the 8-byte UDP header followed by the payload to the IP transmitter, with valid/ready flow control and end-of-frame marking.
- Checksum is transmitted as 0x0000 (checksum disabled, legal for IPv4).

---
 rtl/udp_builder.sv | 238 +++++++++++++++++++++++
 tb/tb_udp_builder.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_builder.sv
// ---------------------------------------------------------------------------
// udp_builder
//
// Transmit-side UDP datagram builder. Application payload bytes are buffered
// in full, because the UDP length field is sent before the data. Once the
// last byte arrives, the block emits the 8-byte UDP header followed by the
// buffered payload to the IP transmitter. The checksum is sent as 0x0000.
//
// Ports:
//   clk            system clock, all logic on the rising edge
//   rst            synchronous active-high reset
//   app_data_in    payload byte from the application
//   app_byte_valid app_data_in is valid this cycle
//   app_eof        marks the last payload byte (qualified by app_byte_valid)
//   app_err        aborts the current frame (qualified by app_byte_valid)
//   app_ready      block accepts application bytes this cycle
//   ip_data_out    UDP byte to the IP transmitter
//   ip_byte_valid  ip_data_out is valid
//   ip_eof         high with the last UDP byte
//   ip_ready       IP transmitter accepts the byte (transfer = valid & ready)
//   tx_drop        one-cycle pulse when a frame is discarded
// ---------------------------------------------------------------------------
module udp_builder #(
  parameter logic [15:0] SRC_PORT    = 16'h1234,
  parameter logic [15:0] DEST_PORT   = 16'hAAAA,
  parameter int          MAX_PAYLOAD = 1472,
  parameter int          ADDR_W      = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] app_data_in,
  input  logic       app_byte_valid,
  input  logic       app_eof,
  input  logic       app_err,
  output logic       app_ready,
  output logic [7:0] ip_data_out,
  output logic       ip_byte_valid,
  output logic       ip_eof,
  input  logic       ip_ready,
  output logic       tx_drop
);

  localparam int            CW      = ADDR_W + 1;
  localparam int            DEPTH   = 1 << ADDR_W;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_PAYLOAD);

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_DRAIN,
    ST_HDR,
    ST_PAYLOAD
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] frame_len_q, frame_len_d;
  logic [15:0]   udp_len_q, udp_len_d;
  logic [2:0]    hdr_idx_q, hdr_idx_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]    ip_data_q, ip_data_d;
  logic          ip_valid_q, ip_valid_d;
  logic          ip_eof_q, ip_eof_d;
  logic          tx_drop_q, tx_drop_d;
  logic          app_ready_q, app_ready_d;

  logic [7:0]    mem [DEPTH];
  logic [7:0]    mem_rd_q;
  logic          wr_en;
  logic          app_accept;
  logic          ip_xfer;
  logic [CW-1:0] rd_ptr_inc;
  logic [2:0]    hdr_idx_inc;

  // Header byte at position idx; bytes 6 and 7 are the disabled checksum.
  function automatic logic [7:0] hdr_byte(input logic [2:0] idx, input logic [15:0] len);
    logic [7:0] b;
    case (idx)
      3'd0:    b = SRC_PORT[15:8];
      3'd1:    b = SRC_PORT[7:0];
      3'd2:    b = DEST_PORT[15:8];
      3'd3:    b = DEST_PORT[7:0];
      3'd4:    b = len[15:8];
      3'd5:    b = len[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Next-state logic. The output register always holds the byte currently
  // offered to IP; on each transfer the following byte is loaded, so the
  // stream holds steady under backpressure. rd_ptr_q is the payload index
  // whose data sits in mem_rd_q, which lets the next payload byte be loaded
  // in the same cycle as a transfer (no bubble at header/payload boundary).
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    frame_len_d = frame_len_q;
    udp_len_d   = udp_len_q;
    hdr_idx_d   = hdr_idx_q;
    rd_ptr_d    = rd_ptr_q;
    ip_data_d   = ip_data_q;
    ip_valid_d  = ip_valid_q;
    ip_eof_d    = ip_eof_q;
    app_ready_d = app_ready_q;
    tx_drop_d   = 1'b0;
    wr_en       = 1'b0;

    app_accept  = app_byte_valid & app_ready_q;
    ip_xfer     = ip_valid_q & ip_ready;
    rd_ptr_inc  = rd_ptr_q + CNT_ONE;
    hdr_idx_inc = hdr_idx_q + 3'd1;

    case (state_q)
      ST_COLLECT: begin
        app_ready_d = 1'b1;
        if (app_accept) begin
          if (app_err) begin
            tx_drop_d = 1'b1;
            count_d   = '0;
          end else if (count_q == CNT_MAX) begin
            // Buffer already full: an eof here still ends the frame, so
            // only a non-final byte needs to drain the remainder.
            tx_drop_d = 1'b1;
            count_d   = '0;
            if (!app_eof) begin
              state_d = ST_DRAIN;
            end
          end else begin
            wr_en = 1'b1;
            if (app_eof) begin
              frame_len_d = count_q + CNT_ONE;
              udp_len_d   = 16'(count_q) + 16'd9;
              count_d     = '0;
              hdr_idx_d   = 3'd0;
              rd_ptr_d    = '0;
              ip_data_d   = SRC_PORT[15:8];
              ip_valid_d  = 1'b1;
              ip_eof_d    = 1'b0;
              app_ready_d = 1'b0;
              state_d     = ST_HDR;
            end else begin
              count_d = count_q + CNT_ONE;
            end
          end
        end
      end

      ST_DRAIN: begin
        app_ready_d = 1'b1;
        if (app_accept && (app_eof || app_err)) begin
          state_d = ST_COLLECT;
        end
      end

      ST_HDR: begin
        if (ip_xfer) begin
          if (hdr_idx_q == 3'd7) begin
            ip_data_d = mem_rd_q;
            ip_eof_d  = (frame_len_q == CNT_ONE);
            rd_ptr_d  = CNT_ONE;
            state_d   = ST_PAYLOAD;
          end else begin
            hdr_idx_d = hdr_idx_inc;
            ip_data_d = hdr_byte(hdr_idx_inc, udp_len_q);
          end
        end
      end

      ST_PAYLOAD: begin
        if (ip_xfer) begin
          if (ip_eof_q) begin
            ip_valid_d  = 1'b0;
            ip_eof_d    = 1'b0;
            ip_data_d   = 8'h00;
            rd_ptr_d    = '0;
            app_ready_d = 1'b1;
            state_d     = ST_COLLECT;
          end else begin
            ip_data_d = mem_rd_q;
            ip_eof_d  = (rd_ptr_inc == frame_len_q);
            rd_ptr_d  = rd_ptr_inc;
          end
        end
      end

      default: begin
        state_d = ST_COLLECT;
      end
    endcase
  end

  // Control and output registers; reset abandons any frame in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_COLLECT;
      count_q     <= '0;
      frame_len_q <= '0;
      udp_len_q   <= '0;
      hdr_idx_q   <= '0;
      rd_ptr_q    <= '0;
      ip_data_q   <= '0;
      ip_valid_q  <= 1'b0;
      ip_eof_q    <= 1'b0;
      tx_drop_q   <= 1'b0;
      app_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      frame_len_q <= frame_len_d;
      udp_len_q   <= udp_len_d;
      hdr_idx_q   <= hdr_idx_d;
      rd_ptr_q    <= rd_ptr_d;
      ip_data_q   <= ip_data_d;
      ip_valid_q  <= ip_valid_d;
      ip_eof_q    <= ip_eof_d;
      tx_drop_q   <= tx_drop_d;
      app_ready_q <= app_ready_d;
    end
  end

  // Payload buffer. The read follows rd_ptr_d so mem_rd_q always holds
  // buffer[rd_ptr_q]. The header phase lasts at least eight cycles, so
  // buffer[0] is re-read after the final write before it is needed.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[count_q[ADDR_W-1:0]] <= app_data_in;
    end
    mem_rd_q <= mem[rd_ptr_d[ADDR_W-1:0]];
  end

  assign app_ready     = app_ready_q;
  assign ip_data_out   = ip_data_q;
  assign ip_byte_valid = ip_valid_q;
  assign ip_eof        = ip_eof_q;
  assign tx_drop       = tx_drop_q;

endmodule

// File: tb/tb_udp_builder.sv
// ---------------------------------------------------------------------------
// tb_udp_builder
//
// Self-checking bench for udp_builder. Two instances are driven from the same
// inputs: one with default parameters and one with MAX_PAYLOAD=16 for the
// buffer-limit scenarios; use_small selects whose outputs are observed.
// Expected UDP streams come from a datagram model built from port constants,
// payload length and payload bytes.
// ---------------------------------------------------------------------------
module tb_udp_builder;

  localparam logic [15:0] SRC  = 16'h1234;
  localparam logic [15:0] DEST = 16'hAAAA;

  logic       clk;
  logic       rst;
  logic [7:0] app_data_in;
  logic       app_byte_valid;
  logic       app_eof;
  logic       app_err;
  logic       ip_ready;
  logic       use_small;

  logic       b_app_ready, b_ip_byte_valid, b_ip_eof, b_tx_drop;
  logic [7:0] b_ip_data_out;
  logic       s_app_ready, s_ip_byte_valid, s_ip_eof, s_tx_drop;
  logic [7:0] s_ip_data_out;

  logic       app_ready, ip_byte_valid, ip_eof, tx_drop;
  logic [7:0] ip_data_out;

  int checks;
  int failures;
  int drop_total;

  logic [7:0] frame20[$];

  udp_builder dut (
    .clk            (clk),
    .rst            (rst),
    .app_data_in    (app_data_in),
    .app_byte_valid (app_byte_valid),
    .app_eof        (app_eof),
    .app_err        (app_err),
    .app_ready      (b_app_ready),
    .ip_data_out    (b_ip_data_out),
    .ip_byte_valid  (b_ip_byte_valid),
    .ip_eof         (b_ip_eof),
    .ip_ready       (ip_ready),
    .tx_drop        (b_tx_drop)
  );

  udp_builder #(
    .MAX_PAYLOAD (16),
    .ADDR_W      (4)
  ) dut_small (
    .clk            (clk),
    .rst            (rst),
    .app_data_in    (app_data_in),
    .app_byte_valid (app_byte_valid),
    .app_eof        (app_eof),
    .app_err        (app_err),
    .app_ready      (s_app_ready),
    .ip_data_out    (s_ip_data_out),
    .ip_byte_valid  (s_ip_byte_valid),
    .ip_eof         (s_ip_eof),
    .ip_ready       (ip_ready),
    .tx_drop        (s_tx_drop)
  );

  assign app_ready     = use_small ? s_app_ready     : b_app_ready;
  assign ip_data_out   = use_small ? s_ip_data_out   : b_ip_data_out;
  assign ip_byte_valid = use_small ? s_ip_byte_valid : b_ip_byte_valid;
  assign ip_eof        = use_small ? s_ip_eof        : b_ip_eof;
  assign tx_drop       = use_small ? s_tx_drop       : b_tx_drop;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Running count of tx_drop pulses seen on the observed instance.
  always @(negedge clk) begin
    if (tx_drop === 1'b1) drop_total++;
  end

  // Datagram model: 8-byte header (ports, length = payload + 8, zero
  // checksum) followed by the payload.
  function automatic void build_expected(input logic [7:0] p[$], output logic [7:0] e[$]);
    logic [15:0] len16;
    len16 = 16'(p.size() + 8);
    e.delete();
    e.push_back(SRC[15:8]);
    e.push_back(SRC[7:0]);
    e.push_back(DEST[15:8]);
    e.push_back(DEST[7:0]);
    e.push_back(len16[15:8]);
    e.push_back(len16[7:0]);
    e.push_back(8'h00);
    e.push_back(8'h00);
    foreach (p[i]) e.push_back(p[i]);
  endfunction

  function automatic void rand_payload(input int n, output logic [7:0] p[$]);
    p.delete();
    for (int i = 0; i < n; i++) p.push_back(8'($urandom));
  endfunction

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    app_byte_valid = 1'b0;
    app_eof = 1'b0;
    app_err = 1'b0;
    ip_ready = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  // Offers payload bytes honouring app_ready; returns just after the
  // accepting edge of the last byte.
  task automatic send_bytes(input logic [7:0] p[$], input int err_at, input bit with_eof);
    int  waited;
    bit  timed_out;
    timed_out = 1'b0;
    for (int i = 0; i < p.size(); i++) begin
      waited = 0;
      @(negedge clk);
      while (app_ready !== 1'b1 && waited < 100) begin
        @(negedge clk);
        waited++;
      end
      if (waited >= 100) timed_out = 1'b1;
      app_byte_valid = 1'b1;
      app_data_in    = p[i];
      app_eof        = with_eof && (i == p.size() - 1);
      app_err        = (i == err_at);
    end
    @(posedge clk);
    #1;
    app_byte_valid = 1'b0;
    app_eof        = 1'b0;
    app_err        = 1'b0;
    checks++;
    if (timed_out) begin
      failures++;
      $display("[TB] FAIL send_ready_wait got app_ready=%b want 1 within 100 cycles", app_ready);
    end
  endtask

  // Watches the IP side for up to budget cycles. mode 0 keeps ip_ready high,
  // mode 1 toggles it 1/0. Records transferred bytes and stream properties.
  task automatic collect(input int mode, input int budget,
                         output logic [7:0] d[$], output int eof_cycles, output int eof_pos,
                         output int valid_cycles, output int stall_err, output int gaps,
                         output bit first_valid, output bit ready_after, output bit valid_after,
                         output bit timed_out);
    bit         prev_stall;
    bit         started;
    logic [7:0] prev_d;
    logic       prev_e;
    d.delete();
    eof_cycles   = 0;
    eof_pos      = -1;
    valid_cycles = 0;
    stall_err    = 0;
    gaps         = 0;
    first_valid  = 1'b0;
    timed_out    = 1'b1;
    prev_stall   = 1'b0;
    started      = 1'b0;
    prev_d       = 8'h00;
    prev_e       = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (c == 0) first_valid = (ip_byte_valid === 1'b1);
      if (prev_stall && (ip_byte_valid !== 1'b1 || ip_data_out !== prev_d || ip_eof !== prev_e))
        stall_err++;
      if (ip_byte_valid === 1'b1) begin
        valid_cycles++;
        started = 1'b1;
        if (ip_eof === 1'b1) eof_cycles++;
      end else if (started) begin
        gaps++;
      end
      ip_ready   = (mode == 0) ? 1'b1 : ((c % 2) == 0);
      prev_stall = (ip_byte_valid === 1'b1) && !ip_ready;
      prev_d     = ip_data_out;
      prev_e     = ip_eof;
      if (ip_byte_valid === 1'b1 && ip_ready) begin
        d.push_back(ip_data_out);
        if (ip_eof === 1'b1) begin
          eof_pos   = d.size();
          timed_out = 1'b0;
          break;
        end
      end
    end
    @(negedge clk);
    ip_ready    = 1'b1;
    ready_after = (app_ready === 1'b1);
    valid_after = (ip_byte_valid === 1'b1);
  endtask

  task automatic test_reset();
    int waited;
    rst = 1'b1;
    app_byte_valid = 1'b1;
    app_data_in = 8'hC3;
    app_eof = 1'b1;
    app_err = 1'b0;
    ip_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (ip_byte_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got %b want 0", ip_byte_valid); end
    checks++;
    if (ip_eof !== 1'b0) begin failures++; $display("[TB] FAIL reset_eof got %b want 0", ip_eof); end
    checks++;
    if (ip_data_out !== 8'h00) begin failures++; $display("[TB] FAIL reset_data got %h want 00", ip_data_out); end
    checks++;
    if (tx_drop !== 1'b0) begin failures++; $display("[TB] FAIL reset_drop got %b want 0", tx_drop); end
    checks++;
    if (app_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_app_ready got %b want 0", app_ready); end
    app_byte_valid = 1'b0;
    app_eof = 1'b0;
    rst = 1'b0;
    waited = 0;
    while (app_ready !== 1'b1 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (app_ready !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_ready got %b want 1", app_ready); end
    checks++;
    if (ip_byte_valid !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_idle got valid=%b want 0", ip_byte_valid); end
  endtask

  task automatic test_basic();
    logic [7:0] e[$];
    logic [7:0] d[$];
    int eof_cycles, eof_pos, valid_cycles, stall_err, gaps;
    bit first_valid, ready_after, valid_after, timed_out;
    rand_payload(20, frame20);
    build_expected(frame20, e);
    send_bytes(frame20, -1, 1'b1);
    collect(0, 60, d, eof_cycles, eof_pos, valid_cycles, stall_err, gaps, first_valid, ready_after, valid_after, timed_out);
    checks++;
    if (d.size() !== e.size()) begin failures++; $display("[TB] FAIL basic_len got %0d bytes want %0d", d.size(), e.size()); end
    for (int i = 0; i < e.size() && i < d.size(); i++) begin
      checks++;
      if (d[i] !== e[i]) begin failures++; $display("[TB] FAIL basic_byte[%0d] got %h want %h", i, d[i], e[i]); end
    end
    checks++;
    if (!first_valid) begin failures++; $display("[TB] FAIL basic_latency got valid=0 want 1 one cycle after eof"); end
    checks++;
    if (valid_cycles !== 28 || gaps !== 0) begin failures++; $display("[TB] FAIL basic_no_bubble got valid_cycles=%0d gaps=%0d want 28/0", valid_cycles, gaps); end
    checks++;
    if (eof_cycles !== 1 || eof_pos !== 28) begin failures++; $display("[TB] FAIL basic_eof got cycles=%0d pos=%0d want 1/28", eof_cycles, eof_pos); end
    checks++;
    if (!ready_after || valid_after) begin failures++; $display("[TB] FAIL basic_after got app_ready=%b valid=%b want 1/0", ready_after, valid_after); end
  endtask

  task automatic test_backpressure();
    logic [7:0] e[$];
    logic [7:0] d[$];
    int eof_cycles, eof_pos, valid_cycles, stall_err, gaps;
    bit first_valid, ready_after, valid_after, timed_out;
    build_expected(frame20, e);
    send_bytes(frame20, -1, 1'b1);
    collect(1, 120, d, eof_cycles, eof_pos, valid_cycles, stall_err, gaps, first_valid, ready_after, valid_after, timed_out);
    checks++;
    if (d.size() !== e.size()) begin failures++; $display("[TB] FAIL bp_len got %0d bytes want %0d", d.size(), e.size()); end
    for (int i = 0; i < e.size() && i < d.size(); i++) begin
      checks++;
      if (d[i] !== e[i]) begin failures++; $display("[TB] FAIL bp_byte[%0d] got %h want %h", i, d[i], e[i]); end
    end
    checks++;
    if (stall_err !== 0) begin failures++; $display("[TB] FAIL bp_stall_stable got %0d unstable stalls want 0", stall_err); end
    checks++;
    if (gaps !== 0) begin failures++; $display("[TB] FAIL bp_valid_continuous got %0d gaps want 0", gaps); end
    checks++;
    if (eof_pos !== 28) begin failures++; $display("[TB] FAIL bp_eof_pos got %0d want 28", eof_pos); end
  endtask

  task automatic test_one_byte();
    logic [7:0] p[$];
    logic [7:0] e[$];
    logic [7:0] d[$];
    int eof_cycles, eof_pos, valid_cycles, stall_err, gaps;
    bit first_valid, ready_after, valid_after, timed_out;
    p.delete();
    p.push_back(8'h5A);
    build_expected(p, e);
    send_bytes(p, -1, 1'b1);
    collect(0, 30, d, eof_cycles, eof_pos, valid_cycles, stall_err, gaps, first_valid, ready_after, valid_after, timed_out);
    checks++;
    if (d.size() !== 9) begin failures++; $display("[TB] FAIL one_len got %0d bytes want 9", d.size()); end
    for (int i = 0; i < e.size() && i < d.size(); i++) begin
      checks++;
      if (d[i] !== e[i]) begin failures++; $display("[TB] FAIL one_byte[%0d] got %h want %h", i, d[i], e[i]); end
    end
    if (d.size() == 9) begin
      checks++;
      if (d[5] !== 8'h09 || d[8] !== 8'h5A) begin failures++; $display("[TB] FAIL one_fields got len_lo=%h data=%h want 09/5A", d[5], d[8]); end
    end
    checks++;
    if (eof_cycles !== 1 || eof_pos !== 9 || gaps !== 0) begin failures++; $display("[TB] FAIL one_eof got cycles=%0d pos=%0d gaps=%0d want 1/9/0", eof_cycles, eof_pos, gaps); end
  endtask

  task automatic test_err_abort();
    logic [7:0] p[$];
    logic [7:0] e[$];
    logic [7:0] d[$];
    int eof_cycles, eof_pos, valid_cycles, stall_err, gaps, drops0;
    bit first_valid, ready_after, valid_after, timed_out;
    drops0 = drop_total;
    rand_payload(7, p);
    send_bytes(p, 6, 1'b0);
    collect(0, 30, d, eof_cycles, eof_pos, valid_cycles, stall_err, gaps, first_valid, ready_after, valid_after, timed_out);
    #1;
    checks++;
    if (drop_total - drops0 !== 1) begin failures++; $display("[TB] FAIL err_drop got %0d pulses want 1", drop_total - drops0); end
    checks++;
    if (valid_cycles !== 0) begin failures++; $display("[TB] FAIL err_no_output got %0d valid cycles want 0", valid_cycles); end
    rand_payload(4, p);
    build_expected(p, e);
    send_bytes(p, -1, 1'b1);
    collect(0, 30, d, eof_cycles, eof_pos, valid_cycles, stall_err, gaps, first_valid, ready_after, valid_after, timed_out);
    checks++;
    if (d.size() !== 12) begin failures++; $display("[TB] FAIL err_next_len got %0d bytes want 12", d.size()); end
    for (int i = 0; i < e.size() && i < d.size(); i++) begin
      checks++;
      if (d[i] !== e[i]) begin failures++; $display("[TB] FAIL err_next_byte[%0d] got %h want %h", i, d[i], e[i]); end
    end
    if (d.size() > 5) begin
      checks++;
      if (d[4] !== 8'h00 || d[5] !== 8'h0C) begin failures++; $display("[TB] FAIL err_next_udp_len got %h%h want 000C", d[4], d[5]); end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] p[$];
    logic [7:0] e[$];
    logic [7:0] d[$];
    int eof_cycles, eof_pos, valid_cycles, stall_err, gaps, drops0;
    bit first_valid, ready_after, valid_after, timed_out;
    use_small = 1'b1;
    do_reset(2);

    drops0 = drop_total;
    rand_payload(17, p);
    send_bytes(p, -1, 1'b1);
    collect(0, 30, d, eof_cycles, eof_pos, valid_cycles, stall_err, gaps, first_valid, ready_after, valid_after, timed_out);
    #1;
    checks++;
    if (drop_total - drops0 !== 1 || valid_cycles !== 0) begin failures++; $display("[TB] FAIL ovf_eof17 got drops=%0d valid_cycles=%0d want 1/0", drop_total - drops0, valid_cycles); end

    drops0 = drop_total;
    rand_payload(20, p);
    send_bytes(p, -1, 1'b1);
    collect(0, 30, d, eof_cycles, eof_pos, valid_cycles, stall_err, gaps, first_valid, ready_after, valid_after, timed_out);
    #1;
    checks++;
    if (drop_total - drops0 !== 1 || valid_cycles !== 0) begin failures++; $display("[TB] FAIL ovf_drain got drops=%0d valid_cycles=%0d want 1/0", drop_total - drops0, valid_cycles); end

    drops0 = drop_total;
    rand_payload(16, p);
    build_expected(p, e);
    send_bytes(p, -1, 1'b1);
    collect(0, 60, d, eof_cycles, eof_pos, valid_cycles, stall_err, gaps, first_valid, ready_after, valid_after, timed_out);
    #1;
    checks++;
    if (d.size() !== 24) begin failures++; $display("[TB] FAIL max_len got %0d bytes want 24", d.size()); end
    for (int i = 0; i < e.size() && i < d.size(); i++) begin
      checks++;
      if (d[i] !== e[i]) begin failures++; $display("[TB] FAIL max_byte[%0d] got %h want %h", i, d[i], e[i]); end
    end
    if (d.size() > 5) begin
      checks++;
      if (d[5] !== 8'h18) begin failures++; $display("[TB] FAIL max_udp_len got %h want 18", d[5]); end
    end
    checks++;
    if (drop_total - drops0 !== 0 || gaps !== 0) begin failures++; $display("[TB] FAIL max_clean got drops=%0d gaps=%0d want 0/0", drop_total - drops0, gaps); end

    use_small = 1'b0;
    do_reset(2);
  endtask

  task automatic test_mid_reset();
    logic [7:0] p[$];
    logic [7:0] e[$];
    logic [7:0] d[$];
    int eof_cycles, eof_pos, valid_cycles, stall_err, gaps, xfers;
    bit first_valid, ready_after, valid_after, timed_out, hit;
    logic [7:0] shown;
    rand_payload(10, p);
    send_bytes(p, -1, 1'b1);
    xfers = 0;
    hit = 1'b0;
    shown = 8'h00;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (xfers == 12 && ip_byte_valid === 1'b1) begin
        shown = ip_data_out;
        rst = 1'b1;
        hit = 1'b1;
        break;
      end
      ip_ready = 1'b1;
      if (ip_byte_valid === 1'b1) xfers++;
    end
    checks++;
    if (!hit || shown !== p[4]) begin failures++; $display("[TB] FAIL midrst_byte5 got reached=%b data=%h want 1/%h", hit, shown, p[4]); end
    @(negedge clk);
    checks++;
    if (ip_byte_valid !== 1'b0 || ip_eof !== 1'b0) begin failures++; $display("[TB] FAIL midrst_idle got valid=%b eof=%b want 0/0", ip_byte_valid, ip_eof); end
    rst = 1'b0;
    rand_payload(3, p);
    build_expected(p, e);
    send_bytes(p, -1, 1'b1);
    collect(0, 30, d, eof_cycles, eof_pos, valid_cycles, stall_err, gaps, first_valid, ready_after, valid_after, timed_out);
    checks++;
    if (d.size() !== 11) begin failures++; $display("[TB] FAIL midrst_next_len got %0d bytes want 11", d.size()); end
    for (int i = 0; i < e.size() && i < d.size(); i++) begin
      checks++;
      if (d[i] !== e[i]) begin failures++; $display("[TB] FAIL midrst_byte[%0d] got %h want %h", i, d[i], e[i]); end
    end
    if (d.size() > 5) begin
      checks++;
      if (d[5] !== 8'h0B) begin failures++; $display("[TB] FAIL midrst_udp_len got %h want 0B", d[5]); end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    drop_total = 0;
    use_small = 1'b0;
    rst = 1'b1;
    app_data_in = 8'h00;
    app_byte_valid = 1'b0;
    app_eof = 1'b0;
    app_err = 1'b0;
    ip_ready = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_one_byte();
    test_err_abort();
    test_overflow();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog got no completion want finish before 1ms");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
